// File: rtl/alu_pipe_regfile.sv
// Two-stage valid/ready ALU pipeline over a small register file: operand stage,
// output stage with writeback, result forwarding into operand fetch, host load/read port.
module alu_pipe_regfile #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic [AW-1:0]    in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [AW-1:0]    out_rd,
    output logic             out_carry,
    output logic             out_zero,
    input  logic             host_wr_en,
    input  logic [AW-1:0]    host_wr_addr,
    input  logic [WIDTH-1:0] host_wr_data,
    input  logic [AW-1:0]    host_rd_addr,
    output logic [WIDTH-1:0] host_rd_data
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [AW-1:0]    s1_rd_q, s1_rd_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [AW-1:0]    out_rd_q, out_rd_d;
    logic             out_carry_q, out_carry_d;
    logic             out_zero_q, out_zero_d;

    logic             s2_adv_s, s1_adv_s, accept_s;
    logic [WIDTH:0]   alu_s;
    logic [WIDTH-1:0] rs_val_s, rt_val_s;

    // Returns {carry, result}; SUB carry is the no-borrow flag of a + ~b + 1.
    function automatic logic [WIDTH:0] alu_eval(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            3'b001:  r = {1'b0, a} + {1'b0, b};
            3'b010:  r = {1'b0, a | b};
            3'b011:  r = {1'b0, a & b};
            3'b100:  r = {1'b0, b[WIDTH-1], b[WIDTH-1:1]};
            3'b101:  r = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
            3'b110:  r = {{WIDTH{1'b0}}, (a < b)};
            3'b111:  r = {{WIDTH{1'b0}}, (a == b)};
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    // Handshake: S2 frees when empty or consumed, S1 moves when S2 frees.
    always_comb begin
        s2_adv_s = !out_valid_q || out_ready;
        s1_adv_s = s1_valid_q && s2_adv_s;
        accept_s = in_valid && (!s1_valid_q || s2_adv_s);
        alu_s    = alu_eval(s1_op_q, s1_a_q, s1_b_q);
    end

    assign in_ready     = !s1_valid_q || s2_adv_s;
    assign host_rd_data = regs_q[host_rd_addr];

    // Operand fetch with per-operand forwarding of the result leaving S1.
    always_comb begin
        if (s1_adv_s && (in_rs == s1_rd_q)) begin
            rs_val_s = alu_s[WIDTH-1:0];
        end else begin
            rs_val_s = regs_q[in_rs];
        end
        if (s1_adv_s && (in_rt == s1_rd_q)) begin
            rt_val_s = alu_s[WIDTH-1:0];
        end else begin
            rt_val_s = regs_q[in_rt];
        end
    end

    // Register file next state: writeback wins over a host write to the same entry.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (s1_adv_s && (s1_rd_q == i[AW-1:0])) begin
                regs_d[i] = alu_s[WIDTH-1:0];
            end else if (host_wr_en && (host_wr_addr == i[AW-1:0])) begin
                regs_d[i] = host_wr_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Pipeline stage next state.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_rd_d      = s1_rd_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_carry_d  = out_carry_q;
        out_zero_d   = out_zero_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_rd_d    = in_rd;
            s1_a_d     = rs_val_s;
            s1_b_d     = rt_val_s;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_adv_s) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_s[WIDTH-1:0];
            out_carry_d  = alu_s[WIDTH];
            out_zero_d   = (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
            out_rd_d     = s1_rd_q;
        end else if (s2_adv_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 3'b000;
            s1_rd_q      <= {AW{1'b0}};
            s1_a_q       <= {WIDTH{1'b0}};
            s1_b_q       <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            out_result_q <= {WIDTH{1'b0}};
            out_rd_q     <= {AW{1'b0}};
            out_carry_q  <= 1'b0;
            out_zero_q   <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_rd_q      <= s1_rd_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_carry_q  <= out_carry_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_carry  = out_carry_q;
    assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_alu_pipe_regfile.sv
// Self-checking bench for alu_pipe_regfile: directed scenarios plus a random
// stream scored against an in-order architectural model of the register file.
`timescale 1ns/100ps
module tb_alu_pipe_regfile;
    localparam int WIDTH = 4;
    localparam int NREGS = 4;
    localparam int AW    = $clog2(NREGS);
    localparam int PW    = AW + 2 + WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [AW-1:0]    in_rs = '0, in_rt = '0, in_rd = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic [AW-1:0]    out_rd;
    logic             out_carry, out_zero;
    logic             host_wr_en = 1'b0;
    logic [AW-1:0]    host_wr_addr = '0, host_rd_addr = '0;
    logic [WIDTH-1:0] host_wr_data = '0;
    logic [WIDTH-1:0] host_rd_data;

    int checks = 0;
    int errors = 0;
    int fires  = 0;
    bit last_acc;
    logic [WIDTH-1:0] mregs [NREGS];
    logic [PW-1:0]    exp_q [$];

    alu_pipe_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_carry(out_carry), .out_zero(out_zero),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data)
    );

    always #10 clk = ~clk;

    // Reference ALU in plain integer arithmetic; returns {carry, result}.
    function automatic logic [WIDTH:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        int ua, ub, m, r;
        logic c;
        m = 1 << WIDTH; ua = int'(a); ub = int'(b); c = 1'b0; r = 0;
        case (op)
            3'd0: begin r = (ua - ub + m) % m; c = (ua >= ub); end
            3'd1: begin r = (ua + ub) % m;     c = (ua + ub >= m); end
            3'd2: r = int'(a | b);
            3'd3: r = int'(a & b);
            3'd4: r = ub / 2 + ((ub >= m / 2) ? m / 2 : 0);
            3'd5: r = (ua * 2) % m + ua / (m / 2);
            3'd6: r = (ua < ub) ? 1 : 0;
            3'd7: r = (ua == ub) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, r[WIDTH-1:0]};
    endfunction

    function automatic logic [PW-1:0] out_pkt();
        return {out_rd, out_carry, out_zero, out_result};
    endfunction

    // One clock: score any result taken, model any instruction accepted.
    task automatic tick();
        logic [WIDTH:0] r;
        logic [PW-1:0]  e;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            fires++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got %h, want no result", out_pkt());
            end else begin
                e = exp_q.pop_front();
                if (out_pkt() !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got %h, want %h", out_pkt(), e);
                end
            end
        end
        if (last_acc) begin
            r = ref_alu(in_op, mregs[in_rs], mregs[in_rt]);
            mregs[in_rd] = r[WIDTH-1:0];
            exp_q.push_back({in_rd, r[WIDTH], (r[WIDTH-1:0] == '0), r[WIDTH-1:0]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
        host_rd_addr = a;
        #1;
        d = host_rd_data;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        tick();
        host_wr_en = 1'b0;
        mregs[a] = d;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [AW-1:0] rs,
                             input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    // Offer one instruction, wait for accept, then one more edge so its result is visible.
    task automatic do_one(input logic [2:0] op, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        bit ok;
        ok = 1'b0;
        set_instr(op, rs, rt, rd);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            ok = last_acc;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL accept_timeout: got no accept, want accept"); end
        tick();
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0; out_ready = 1'b1; k = 0;
        while (exp_q.size() != 0 && k < 50) begin tick(); k++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] d;
        checks++;
        if ({out_valid, out_pkt()} !== {1'b0, {PW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_out: got valid=%b pkt=%h, want 0/0", out_valid, out_pkt());
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
        for (int i = 0; i < NREGS; i++) begin
            read_reg(AW'(i), d);
            checks++;
            if (d !== '0) begin errors++; $display("FAIL reset_reg%0d: got %h, want 0", i, d); end
        end
        tick();
    endtask

    task automatic test_add_sub();
        logic [WIDTH-1:0] d;
        host_write(2'd0, 4'd5);
        host_write(2'd1, 4'd3);
        do_one(3'b001, 2'd0, 2'd1, 2'd2);
        checks++;
        if ({out_valid, out_pkt()} !== {1'b1, 2'd2, 1'b0, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL add: got valid=%b pkt=%h, want 1/%h", out_valid, out_pkt(), {2'd2, 2'b00, 4'd8});
        end
        drain();
        read_reg(2'd2, d);
        checks++;
        if (d !== 4'd8) begin errors++; $display("FAIL add_wb: got %h, want 8", d); end
        do_one(3'b000, 2'd1, 2'd0, 2'd3);
        checks++;
        if (out_pkt() !== {2'd3, 1'b0, 1'b0, 4'b1110}) begin
            errors++;
            $display("FAIL sub_borrow: got %h, want %h", out_pkt(), {2'd3, 2'b00, 4'b1110});
        end
        drain();
        do_one(3'b000, 2'd0, 2'd0, 2'd3);
        checks++;
        if (out_pkt() !== {2'd3, 1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL sub_zero: got %h, want %h", out_pkt(), {2'd3, 2'b11, 4'd0});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        host_write(2'd0, 4'd5); host_write(2'd1, 4'd3); host_write(2'd2, 4'd0);
        set_instr(3'b001, 2'd0, 2'd1, 2'd2);
        in_valid = 1'b1;
        tick();
        checks++;
        if (!last_acc) begin errors++; $display("FAIL b2b_acc0: got 0, want 1"); end
        set_instr(3'b010, 2'd2, 2'd0, 2'd3);
        tick();
        checks++;
        if (!last_acc) begin errors++; $display("FAIL b2b_nostall: got 0, want 1"); end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_pkt()} !== {1'b1, 2'd3, 1'b0, 1'b0, 4'd13}) begin
            errors++;
            $display("FAIL b2b_bypass: got valid=%b pkt=%h, want 1/%h", out_valid, out_pkt(), {2'd3, 2'b00, 4'd13});
        end
        drain();
        read_reg(2'd3, d);
        checks++;
        if (d !== 4'd13) begin errors++; $display("FAIL b2b_wb: got %h, want 13", d); end
    endtask

    task automatic test_shift_cmp();
        logic [2:0]       ops [4] = '{3'b100, 3'b101, 3'b110, 3'b111};
        logic [AW-1:0]    rss [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic [AW-1:0]    rts [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
        logic [WIDTH-1:0] want [4] = '{4'b1100, 4'b0011, 4'b0001, 4'b0001};
        host_write(2'd0, 4'b1001); host_write(2'd1, 4'd3); host_write(2'd2, 4'd5);
        for (int i = 0; i < 4; i++) begin
            do_one(ops[i], rss[i], rts[i], 2'd3);
            checks++;
            if (out_pkt() !== {2'd3, 1'b0, 1'b0, want[i]}) begin
                errors++;
                $display("FAIL shift_cmp op%b: got %h, want %h", ops[i], out_pkt(), {2'd3, 2'b00, want[i]});
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int sent, f0;
        logic [PW-1:0] held;
        logic [WIDTH-1:0] d;
        sent = 0; held = '0;
        out_ready = 1'b0;
        set_instr(3'($urandom_range(7)), AW'($urandom), AW'($urandom), AW'($urandom));
        for (int c = 0; c < 4; c++) begin
            in_valid = (sent < 3);
            tick();
            if (last_acc) begin
                sent++;
                set_instr(3'($urandom_range(7)), AW'($urandom), AW'($urandom), AW'($urandom));
            end
            if (c == 1) begin
                held = out_pkt();
                checks++;
                if (out_valid !== 1'b1 || held !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_first: got valid=%b pkt=%h, want 1/%h", out_valid, held, exp_q[0]);
                end
            end else if (c > 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_pkt() !== held) begin
                    errors++;
                    $display("FAIL bp_stable: got valid=%b pkt=%h, want 1/%h", out_valid, out_pkt(), held);
                end
            end
        end
        checks++;
        if (sent != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got accepted=%0d in_ready=%b, want 2/0", sent, in_ready);
        end
        f0 = fires;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sent < 3; k++) begin
            tick();
            if (last_acc) sent++;
            in_valid = (sent < 3);
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (fires - f0 != 3) begin errors++; $display("FAIL bp_count: got %0d results, want 3", fires - f0); end
        for (int i = 0; i < NREGS; i++) begin
            read_reg(AW'(i), d);
            checks++;
            if (d !== mregs[i]) begin errors++; $display("FAIL bp_reg%0d: got %h, want %h", i, d, mregs[i]); end
        end
    endtask

    task automatic test_host_conflict();
        logic [WIDTH-1:0] d1, d2, d3;
        host_write(2'd0, 4'd1); host_write(2'd1, 4'd1);
        set_instr(3'b001, 2'd0, 2'd0, 2'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        host_wr_en = 1'b1; host_wr_addr = 2'd1; host_wr_data = 4'd7;
        tick();
        host_wr_en = 1'b0;
        drain();
        read_reg(2'd1, d1);
        checks++;
        if (d1 !== 4'd2) begin errors++; $display("FAIL host_conflict: got %h, want 2", d1); end
        set_instr(3'b001, 2'd0, 2'd0, 2'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        host_wr_en = 1'b1; host_wr_addr = 2'd3; host_wr_data = 4'd6;
        tick();
        host_wr_en = 1'b0;
        mregs[3] = 4'd6;
        drain();
        read_reg(2'd2, d2);
        read_reg(2'd3, d3);
        checks++;
        if (d2 !== 4'd2 || d3 !== 4'd6) begin
            errors++;
            $display("FAIL host_other_addr: got r2=%h r3=%h, want 2/6", d2, d3);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < NREGS; i++) host_write(AW'(i), WIDTH'($urandom));
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(9) < 7);
                set_instr(3'($urandom_range(7)), AW'($urandom), AW'($urandom), AW'($urandom));
            end
            out_ready = ($urandom_range(9) < 7);
            tick();
        end
        drain();
        for (int i = 0; i < NREGS; i++) begin
            read_reg(AW'(i), d);
            checks++;
            if (d !== mregs[i]) begin errors++; $display("FAIL rand_reg%0d: got %h, want %h", i, d, mregs[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [WIDTH-1:0] d;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_instr(3'b010, 2'd0, 2'd1, 2'd3);
        repeat (3) tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got valid=%b, want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_pkt()} !== {1'b0, {PW{1'b0}}}) begin
            errors++;
            $display("FAIL rst_mid_out: got valid=%b pkt=%h, want 0/0", out_valid, out_pkt());
        end
        for (int i = 0; i < NREGS; i++) begin
            read_reg(AW'(i), d);
            checks++;
            if (d !== '0) begin errors++; $display("FAIL rst_mid_reg%0d: got %h, want 0", i, d); end
        end
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_shift_cmp();
        test_backpressure();
        test_host_conflict();
        test_random();
        test_reset_midstream();
        test_add_sub();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_pipe_regfile.md
Name: alu_pipe_regfile

Overview:
- Successor to the 4-bit combinational decode-and-execute datapath.
- Parametrised WIDTH-bit, 8-op ALU fed by an NREGS-entry register file.
- Two-stage valid/ready pipeline with writeback to the register file, result bypass and a host load/read port for board switches and the seven-segment display.

Parameters:
- WIDTH, 4, operand/result width; must be >= 2.
- NREGS, 4, register count; power of two, >= 2. AW = $clog2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- in_op  in  3  opcode.
- in_rs  in  AW  source register rs.
- in_rt  in  AW  source register rt.
- in_rd  in  AW  destination register.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out_result  out  WIDTH  ALU result.
- out_rd  out  AW  destination of the result.
- out_carry  out  1  carry / no-borrow flag.
- out_zero  out  1  out_result == 0.
- host_wr_en  in  1  host register write.
- host_wr_addr  in  AW  host write address.
- host_wr_data  in  WIDTH  host write data.
- host_rd_addr  in  AW  host read address.
- host_rd_data  out  WIDTH  combinational read of regs[host_rd_addr].

Behaviour:
- Reset (async, rst_n=0): all regs = 0; S1 and S2 valid = 0; out_valid = 0; out_result = 0; out_rd = 0; out_carry = 0; out_zero = 0. Any in-flight instructions are discarded.
- Opcodes:
  - 000: SUB, rs-rt.
  - 001: ADD, rs+rt.
  - 010: OR.
  - 011: AND.
  - 100: arithmetic right shift of rt by 1, sign bit kept.
  - 101: circular left shift of rs by 1.
  - 110: unsigned LT, result {0..0, rs<rt}.
  - 111: EQ, result {0..0, rs==rt}.
- Arithmetic is modulo 2^WIDTH.
- Carry:
  - ADD: carry-out.
  - SUB: carry-out of rs + ~rt + 1, i.e. 1 = no borrow.
  - All other ops: 0.
- Stage S1 (operand register): on accept, latches op, rd, and the rs/rt operand values.
- Stage S2 (output register): holds result, flags and rd; it drives the out_* ports.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv.
- On s1_adv:
  - The ALU result is loaded into S2; out_valid = 1 on the next edge.
  - regs[s1_rd] is written with the result on the same edge.
- If S2 empties with no s1_adv, out_valid goes to 0.
- Latency: accept at edge N gives out_valid at edge N+1 if not stalled. Throughput is 1 instruction/cycle.
- Bypass: if an instruction is accepted in the same cycle as s1_adv, and in_rs or in_rt == s1_rd, the S1 ALU result is forwarded instead of the stale register value. Forwarding is per operand.
- Write conflicts:
  - Pipeline writeback has priority over a host write to the same address in the same cycle; the host write is dropped.
  - A host write to a different address completes normally.
- Host writes are not bypassed. A read at accept sees a host write only from the next cycle.
- Backpressure: while out_valid && !out_ready, S2 holds and S1 holds. in_ready = 0 once S1 is full.
- Ordering: results emerge in issue order. No loss and no duplication under any valid/ready pattern.
- Output stability: out_* are stable while out_valid && !out_ready.
- host_rd_data reflects the register array only, never the bypass path.

Test Plan:
- Reset, host write r0=5, r1=3, then ADD rd=2 rs=0 rt=1: out_result=8, carry=0, zero=0 one cycle after accept; host_rd_addr=2 reads 8.
- SUB rd=3 rs=1 rt=0 (3-5): out_result=4'b1110, carry=0. Then SUB rs=0 rt=0: result=0, zero=1, carry=1.
- Back-to-back dependency: ADD r2=r0+r1 (8), next cycle OR rd=3 rs=2 rt=0: out_result=13 via bypass, no stall cycle, r3=13.
- Shifts and compares, with r0=4'b1001, r1=3, r2=5:
  - op100 rt=r0: result 4'b1100.
  - op101 rs=r0: result 4'b0011.
  - op110 r1<r2: result 0001.
  - op111 r2==r2: result 0001.
- Backpressure: out_ready=0 for 4 cycles while 3 instructions are offered: 2 accepted, in_ready=0, out_* held stable. Releasing out_ready yields 3 results in order, each written once.
- Host write r1=7 in the same cycle a pipeline writeback to r1=2 occurs: r1=2. Reset asserted mid-stream with out_valid=1: out_valid=0 and all regs=0 immediately, without waiting for clk.
